prm_edge_scan: RTL and testbench

Sequencer and result packer wrapped around one `prm_oblgc_chk*` obstacle-logic check instance. It walks a 15-bit configuration-code range, drives each code onto the checker's A..O inputs, and samples the checker's combinational `edge_mask`. It packs one result bit per code into 32-bit words and streams them out over a valid/ready interface to the PRM roadmap edge-table writer.

---
 rtl/prm_edge_scan.sv | 217 +++++++++++++++++++++
 tb/tb_prm_edge_scan.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_scan.sv
`default_nettype none
// ============================================================================
// Module   : prm_edge_scan
// Purpose  : Walks an inclusive range of configuration codes through one
//            prm_oblgc_chk obstacle-logic checker, one code per cycle.
//            Packs the returned edge_mask bits into WORD_W-bit words and
//            streams them to the roadmap edge-table writer over valid/ready.
// Config   : PRM_SCAN_BLKCNT_EN - when defined, blocked_cnt counts the
//            blocked codes. Otherwise blocked_cnt is tied to 0.
// Ports    : clk, rst_n          - clock, async active-low reset
//            start               - begin a scan (honoured only when idle)
//            first_idx/last_idx  - inclusive code range, captured on start
//            busy, done          - scan in progress / one-cycle end pulse
//            chk_code, chk_mask  - code to checker / its combinational result
//            out_valid/out_ready - output word handshake
//            out_data/out_base   - packed bits / code of out_data[0]
//            out_last            - final word of the scan
//            blocked_cnt         - blocked codes in the current or last scan
// Revision : 1.0 - initial release
// ============================================================================
module prm_edge_scan #(
  parameter int IDX_W  = 15,
  parameter int WORD_W = 32,  // must be a power of two
  parameter int CNT_W  = 16   // must be >= IDX_W+1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_idx,
  input  logic [IDX_W-1:0]  last_idx,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  chk_code,
  input  logic              chk_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_base,
  output logic              out_last,
  output logic [CNT_W-1:0]  blocked_cnt
);

  localparam int OFF_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] C_WORD_STEP = IDX_W'(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IDX_W-1:0]  r_code;
  logic [IDX_W-1:0]  r_last;
  logic [IDX_W-1:0]  r_base;
  logic [WORD_W-1:0] r_pack;
  logic              r_start_d;
  logic              r_out_valid;
  logic [WORD_W-1:0] r_out_data;
  logic [IDX_W-1:0]  r_out_base;
  logic              r_out_last;

  logic [OFF_W-1:0]  w_off;
  logic              w_is_last;
  logic              w_commit_pt;
  logic              w_can_commit;
  logic              w_sample;
  logic              w_commit;
  logic              w_start_ok;
  logic [WORD_W-1:0] w_packed;
  logic              w_done;
  logic              w_busy;

  // Bit position within the word: only the low bits of the difference
  // matter since base always advances by a whole word.
  assign w_off        = r_code[OFF_W-1:0] - r_base[OFF_W-1:0];
  assign w_is_last    = (r_code == r_last);
  assign w_commit_pt  = (&w_off) || w_is_last;
  assign w_can_commit = !r_out_valid || out_ready;
  // A commit point with the output register still occupied stalls the
  // walk; the same code is resampled once the slot frees up.
  assign w_sample     = (r_state == ST_SCAN) && !(w_commit_pt && !w_can_commit);
  assign w_commit     = w_sample && w_commit_pt;
  assign w_start_ok   = (r_state == ST_IDLE) && start;
  assign w_packed     = r_pack | ({{(WORD_W-1){1'b0}}, chk_mask} << w_off);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    // busy also covers the cycle right after an accepted start, so an empty
    // range still shows busy alongside its done pulse.
    w_busy      = r_start_d;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (first_idx > last_idx) ? ST_FIN : ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_busy = 1'b1;
        if (w_sample && w_is_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
        if (r_out_valid && out_ready) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Code walk and packing
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code    <= '0;
      r_last    <= '0;
      r_base    <= '0;
      r_pack    <= '0;
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= w_start_ok;
      if (w_start_ok) begin
        r_code <= first_idx;
        r_last <= last_idx;
        r_base <= first_idx;
        r_pack <= '0;
      end else if (w_sample) begin
        // The walk leaves SCAN at last_idx, so a wrap of the increment at
        // the top of the code space is never observed as a sample.
        r_code <= r_code + 1'b1;
        if (w_commit) begin
          r_pack <= '0;
          r_base <= r_base + C_WORD_STEP;
        end else begin
          r_pack <= w_packed;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output word register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_base  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_commit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_packed;
        r_out_base  <= r_base;
        r_out_last  <= w_is_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Blocked-code counter
  // --------------------------------------------------------------------------
`ifdef PRM_SCAN_BLKCNT_EN
  logic [CNT_W-1:0] r_blk_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt <= '0;
    end else if (w_start_ok) begin
      r_blk_cnt <= '0;
    end else if (w_sample && chk_mask) begin
      r_blk_cnt <= r_blk_cnt + 1'b1;
    end
  end

  assign blocked_cnt = r_blk_cnt;
`else
  assign blocked_cnt = '0;
`endif

  assign busy      = w_busy;
  assign done      = w_done;
  assign chk_code  = r_code;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_base  = r_out_base;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_prm_edge_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_prm_edge_scan
// Purpose  : Self-checking bench for prm_edge_scan. A behavioural model
//            builds the expected word list directly from the mask table and
//            the code range; scenarios cover timing, stalls, empty ranges,
//            ignored starts, mid-scan reset and randomized ranges/readiness.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prm_edge_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [14:0] first_idx = '0;
  logic [14:0] last_idx = '0;
  logic        busy;
  logic        done;
  logic [14:0] chk_code;
  logic        chk_mask;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [14:0] out_base;
  logic        out_last;
  logic [15:0] blocked_cnt;

  bit mask_mem [0:32767];

  int errors = 0;
  int checks = 0;

  logic [31:0] got_data [$];
  logic [14:0] got_base [$];
  logic        got_last [$];
  logic [31:0] exp_data [$];
  logic [14:0] exp_base [$];
  logic        exp_last [$];
  int          exp_blk;
  int          valid_n;
  int          done_n;

  always #5 clk = ~clk;

  // The checker is combinational: its answer is a table lookup on chk_code.
  assign chk_mask = mask_mem[chk_code];

  prm_edge_scan #(.IDX_W(15), .WORD_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .first_idx  (first_idx),
    .last_idx   (last_idx),
    .busy       (busy),
    .done       (done),
    .chk_code   (chk_code),
    .chk_mask   (chk_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_base   (out_base),
    .out_last   (out_last),
    .blocked_cnt(blocked_cnt)
  );

  // Reference: one word per 32 codes from first, bits beyond last are 0.
  task automatic build_expected(input int first, input int last);
    exp_data.delete(); exp_base.delete(); exp_last.delete();
    exp_blk = 0;
    for (int b = first; b <= last; b += 32) begin
      logic [31:0] w;
      logic [14:0] bb;
      w = '0;
      for (int k = 0; k < 32 && (b + k) <= last; k++) begin
        w[k] = mask_mem[b + k];
        if (mask_mem[b + k]) exp_blk++;
      end
      bb = b[14:0];
      exp_data.push_back(w);
      exp_base.push_back(bb);
      exp_last.push_back((b + 32) > last);
    end
`ifndef PRM_SCAN_BLKCNT_EN
    exp_blk = 0;
`endif
  endtask

  task automatic fill_random(input int first, input int last);
    for (int c = first; c <= last; c++) mask_mem[c] = 1'($urandom_range(0, 1));
  endtask

  // ready_mode: 0 = always ready, 1 = random, 2 = held low until hold_n.
  task automatic run_scan(input int first, input int last, input int ready_mode,
                          input int hold_n, input int poke_n, input int stall_n,
                          input int stall_code, input string tag);
    int          n;
    bit          finished;
    bit          prev_hold;
    logic [31:0] prev_data;
    logic [14:0] prev_base;
    logic [14:0] fv;
    logic [14:0] sc;
    bit          exp_busy;
    fv = first[14:0];
    sc = stall_code[14:0];
    exp_busy = (first > last);
    build_expected(first, last);
    got_data.delete(); got_base.delete(); got_last.delete();
    valid_n = -1; done_n = -1;
    @(negedge clk);
    first_idx = first[14:0];
    last_idx  = last[14:0];
    start     = 1'b1;
    out_ready = (ready_mode == 0);
    n = 0; finished = 0; prev_hold = 0; prev_data = '0; prev_base = '0;
    while (!finished && n < 3000) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == 1) begin
        checks++;
        if (chk_code !== fv) begin
          errors++; $display("FAIL %s first_code: got %h want %h", tag, chk_code, fv);
        end
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
        end
      end
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_base !== prev_base) begin
          errors++;
          $display("FAIL %s hold_stable n=%0d: got v=%b d=%h b=%h want v=1 d=%h b=%h",
                   tag, n, out_valid, out_data, out_base, prev_data, prev_base);
        end
      end
      if (out_valid === 1'b1 && valid_n < 0) valid_n = n;
      if (n == stall_n) begin
        checks++;
        if (chk_code !== sc) begin
          errors++; $display("FAIL %s stall_code: got %h want %h", tag, chk_code, sc);
        end
      end
      if (n == poke_n) begin
        start     = 1'b1;
        first_idx = 15'($urandom_range(0, 32767));
        last_idx  = 15'($urandom_range(0, 32767));
      end
      if (done === 1'b1) begin
        done_n = n;
        finished = 1;
        checks++;
        if (busy !== exp_busy) begin
          errors++; $display("FAIL %s busy_at_done: got %b want %b", tag, busy, exp_busy);
        end
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL %s valid_at_done: got %b want 0", tag, out_valid);
        end
        checks++;
        if (blocked_cnt !== 16'(exp_blk)) begin
          errors++; $display("FAIL %s blocked_cnt: got %0d want %0d", tag, blocked_cnt, exp_blk);
        end
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (n >= hold_n);
      endcase
      prev_hold = (out_valid === 1'b1) && !out_ready;
      prev_data = out_data;
      prev_base = out_base;
      if (out_valid === 1'b1 && out_ready) begin
        got_data.push_back(out_data);
        got_base.push_back(out_base);
        got_last.push_back(out_last);
      end
    end
    start = 1'b0;
    if (!finished) begin
      checks++; errors++;
      $display("FAIL %s timeout: got no done want done", tag);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s after_done: got done=%b busy=%b want 0 0", tag, done, busy);
    end
    checks++;
    if (got_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL %s word_count: got %0d want %0d", tag, got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_base[i] !== exp_base[i] || got_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL %s word%0d: got d=%h b=%h l=%b want d=%h b=%h l=%b", tag, i,
                 got_data[i], got_base[i], got_last[i], exp_data[i], exp_base[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, chk_code, out_valid, out_data, out_base, out_last, blocked_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_values: got busy=%b done=%b code=%h v=%b d=%h b=%h l=%b cnt=%0d want all 0",
               busy, done, chk_code, out_valid, out_data, out_base, out_last, blocked_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_word;
    logic [31:0] w0;
    for (int c = 0; c < 32; c++) mask_mem[c] = (c % 2 == 0);
    run_scan(0, 31, 0, 0, -1, -1, 0, "single_word");
    checks++;
    if (valid_n != 33) begin
      errors++; $display("FAIL single_word valid_latency: got %0d want 33", valid_n);
    end
    checks++;
    if (done_n != 34) begin
      errors++; $display("FAIL single_word done_latency: got %0d want 34", done_n);
    end
    w0 = (got_data.size() > 0) ? got_data[0] : 32'h0;
    checks++;
    if (w0 !== 32'h5555_5555) begin
      errors++; $display("FAIL single_word data: got %h want 55555555", w0);
    end
  endtask

  task automatic test_two_words;
    logic [31:0] w1;
    for (int c = 5; c <= 40; c++) mask_mem[c] = 1'b1;
    run_scan(5, 40, 0, 0, -1, -1, 0, "two_words");
    w1 = (got_data.size() > 1) ? got_data[1] : 32'h0;
    checks++;
    if (w1 !== 32'h0000_000F) begin
      errors++; $display("FAIL two_words tail: got %h want 0000000f", w1);
    end
  endtask

  // Output blocked: word 1 (codes 5..36) sits unaccepted, so the walk
  // stalls at the next commit point, the last code 40.
  task automatic test_stall;
    for (int c = 5; c <= 40; c++) mask_mem[c] = 1'b1;
    run_scan(5, 40, 2, 50, -1, 45, 40, "stall");
  endtask

  task automatic test_empty_range;
    run_scan(10, 9, 0, 0, -1, -1, 0, "empty");
    checks++;
    if (done_n != 1) begin
      errors++; $display("FAIL empty done_latency: got %0d want 1", done_n);
    end
    checks++;
    if (valid_n != -1) begin
      errors++; $display("FAIL empty no_valid: got valid at %0d want none", valid_n);
    end
  endtask

  task automatic test_busy_start;
    fill_random(100, 180);
    run_scan(100, 180, 0, 0, 10, -1, 0, "busy_start");
  endtask

  task automatic test_reset_mid_scan;
    fill_random(0, 100);
    @(negedge clk);
    first_idx = 15'd0; last_idx = 15'd100; start = 1'b1; out_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL midreset precondition_valid: got %b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, chk_code, out_valid, out_data, out_base, out_last, blocked_cnt} !== '0) begin
      errors++;
      $display("FAIL midreset async_clear: got busy=%b done=%b code=%h v=%b d=%h b=%h l=%b cnt=%0d want all 0",
               busy, done, chk_code, out_valid, out_data, out_base, out_last, blocked_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fill_random(7, 77);
    run_scan(7, 77, 1, 0, -1, -1, 0, "after_reset");
  endtask

  task automatic test_random;
    int f;
    int l;
    for (int t = 0; t < 6; t++) begin
      case (t)
        0: begin f = 32767 - $urandom_range(0, 90); l = 32767; end
        1: begin f = $urandom_range(0, 32000); l = f; end
        2: begin f = $urandom_range(0, 1000); l = f + 63; end
        default: begin f = $urandom_range(0, 30000); l = f + $urandom_range(0, 150); end
      endcase
      fill_random(f, l);
      run_scan(f, l, 1, 0, -1, -1, 0, $sformatf("random%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_stall();
    test_empty_range();
    test_busy_start();
    test_reset_mid_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
